divisor: RTL and testbench
==========================

DIVISOR -- requirements
Module: divisor

Interface
REQ-001 SHALL have parameter N_W, default 16, dividend and quotient width.
REQ-002 SHALL have parameter D_W, default 8, divisor and remainder width.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request to load operands and begin a division.
REQ-006 SHALL have port A  input  N_W  dividend.
REQ-007 SHALL have port B  input  D_W  divisor.
REQ-008 SHALL have port q  output  N_W  quotient, registered.
REQ-009 SHALL have port r  output  D_W  remainder, registered.
REQ-010 SHALL have port busy  output  1  high while a division is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when q and r become valid.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag, registered with done.
REQ-013 SHALL have port contador  output  $clog2(N_W)+1  number of iterations completed.

Function
REQ-014 SHALL implement restoring division: one quotient bit per clock, MSB first.
REQ-015 SHALL use an FSM with states IDLE, CALC and DONE.
REQ-016 SHALL, in IDLE with start=1 at edge 0, latch A and B, clear contador, and enter CALC; busy=1 from edge 0.
REQ-017 SHALL perform one iteration at each of edges 1..N_W, incrementing contador at each one; partial remainder is D_W+1 bits wide.
REQ-018 SHALL, at edge N_W, update q and r, set done=1, clear busy, and enter DONE.
REQ-019 SHALL return from DONE to IDLE on the next edge, clearing done; q, r and dz hold until the next accepted start.
REQ-020 SHALL ignore start while in CALC or DONE, with no effect on latched operands.
REQ-021 SHALL accept start in IDLE in the same cycle in which done has just fallen, allowing back-to-back divisions every N_W+2 cycles.
REQ-022 SHALL handle B=0 as follows: accept start, skip CALC, and at edge 1 give q=all ones, r=A[D_W-1:0], dz=1, done=1.
REQ-023 SHALL clear dz on every accepted start with B!=0.
REQ-024 SHALL produce A=0 -> q=0, r=0, with full latency.

Reset
REQ-025 SHALL, on rst=0 at any time including mid-CALC, immediately force IDLE with q=0, r=0, busy=0, done=0, dz=0, contador=0.
REQ-026 SHALL accept start no earlier than the first rising edge after rst deasserts; an aborted division produces no done.

Configuration
REQ-027 SHALL honour the macro DIVISOR_SIGNED_EN.
REQ-028 SHALL, with DIVISOR_SIGNED_EN defined, treat A and B as two's complement: divide magnitudes, quotient truncates toward zero, remainder takes the sign of A; sign fix-up is applied in the edge-N_W register write, so latency is unchanged.
REQ-029 SHALL, with DIVISOR_SIGNED_EN defined, give the most-negative A divided by -1 as q=most-negative A, r=0, with no flag.
REQ-030 SHALL, without DIVISOR_SIGNED_EN, operate unsigned only, with no sign logic synthesized.

Structure
REQ-031 SHALL take the FSM state encoding (IDLE, CALC, DONE) and default widths from shared package divisor_pkg.
REQ-032 SHALL place the single-iteration compare/subtract/shift in combinational sub-module divisor_paso, instantiated once.

Verification
REQ-033 SHALL cover: A=100, B=7, start -> after 16 edges q=14, r=2, done pulse of 1 cycle, contador=16.
REQ-034 SHALL cover: A=65535, B=255 -> q=257, r=0; then A=0, B=3 -> q=0, r=0.
REQ-035 SHALL cover: B=0, A=1234 -> at edge 1 dz=1, q=16'hFFFF, r=8'hD2, done=1; a following A=9, B=3 -> q=3, dz=0.
REQ-036 SHALL cover: start held high through CALC with changing A/B -> result matches operands latched at edge 0, and exactly one done pulse.
REQ-037 SHALL cover: rst=0 asserted at iteration 8 -> outputs zero immediately, no done; a new division afterwards is correct.
REQ-038 SHALL cover, with DIVISOR_SIGNED_EN: A=-100, B=7 -> q=-14, r=-2; A=100, B=-7 -> q=-14, r=2.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared types and default widths for the divisor block.
// Optional feature macro: DIVISOR_SIGNED_EN (two's complement operands).
package divisor_pkg;

    localparam int N_W_DEF = 16;
    localparam int D_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/divisor_paso.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference when it does not go negative.
module divisor_paso
    import divisor_pkg::*;
#(
    parameter int D_W = D_W_DEF
) (
    input  logic [D_W:0]   rem_i,
    input  logic           bit_i,
    input  logic [D_W-1:0] div_i,
    output logic [D_W:0]   rem_o,
    output logic           q_bit_o
);

    logic [D_W:0] trial_s;
    logic [D_W:0] diff_s;

    // Trial subtraction; a set top bit in the incoming remainder always exceeds the divisor
    always_comb begin
        trial_s = {rem_i[D_W-1:0], bit_i};
        diff_s  = trial_s - {1'b0, div_i};
        q_bit_o = rem_i[D_W] | (trial_s >= {1'b0, div_i});
        if (q_bit_o) begin
            rem_o = diff_s;
        end else begin
            rem_o = trial_s;
        end
    end

endmodule

// File: rtl/divisor.sv
// Sequential restoring divider producing one quotient bit per clock, MSB first.
// Define DIVISOR_SIGNED_EN for two's complement operands (truncating quotient).
module divisor
    import divisor_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_W-1:0]       A,
    input  logic [D_W-1:0]       B,
    output logic [N_W-1:0]       q,
    output logic [D_W-1:0]       r,
    output logic                 busy,
    output logic                 done,
    output logic                 dz,
    output logic [$clog2(N_W):0] contador
);

    localparam int C_W = $clog2(N_W) + 1;
    localparam logic [C_W-1:0] CNT_ONE  = C_W'(1);
    localparam logic [C_W-1:0] CNT_LAST = C_W'(N_W - 1);

    state_t         state_q, state_d;
    logic [N_W-1:0] work_q, work_d;
    logic [D_W-1:0] div_q, div_d;
    logic [D_W:0]   rem_q, rem_d;
    logic [C_W-1:0] cnt_q, cnt_d;
    logic [N_W-1:0] quo_q, quo_d;
    logic [D_W-1:0] res_q, res_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           dz_q, dz_d;

    logic [D_W:0]   rem_nxt_s;
    logic           q_bit_s;
    logic [N_W-1:0] work_nxt_s;
    logic [N_W-1:0] a_mag_s;
    logic [D_W-1:0] b_mag_s;
    logic [N_W-1:0] quo_fix_s;
    logic [D_W-1:0] res_fix_s;
    logic [D_W-1:0] res_dz_s;

    divisor_paso #(.D_W(D_W)) u_paso (
        .rem_i   (rem_q),
        .bit_i   (work_q[N_W-1]),
        .div_i   (div_q),
        .rem_o   (rem_nxt_s),
        .q_bit_o (q_bit_s)
    );

    // The dividend register doubles as the quotient accumulator
    assign work_nxt_s = {work_q[N_W-2:0], q_bit_s};

`ifdef DIVISOR_SIGNED_EN
    logic sa_q, sa_d;
    logic sq_q, sq_d;

    // The core divides magnitudes; signs are reapplied on the final write
    assign a_mag_s   = A[N_W-1] ? -A : A;
    assign b_mag_s   = B[D_W-1] ? -B : B;
    assign quo_fix_s = sq_q ? -work_nxt_s : work_nxt_s;
    assign res_fix_s = sa_q ? -rem_nxt_s[D_W-1:0] : rem_nxt_s[D_W-1:0];
    assign res_dz_s  = sa_q ? -work_q[D_W-1:0] : work_q[D_W-1:0];
`else
    assign a_mag_s   = A;
    assign b_mag_s   = B;
    assign quo_fix_s = work_nxt_s;
    assign res_fix_s = rem_nxt_s[D_W-1:0];
    assign res_dz_s  = work_q[D_W-1:0];
`endif

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        div_d   = div_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        res_d   = res_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dz_d    = dz_q;
`ifdef DIVISOR_SIGNED_EN
        sa_d    = sa_q;
        sq_d    = sq_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = a_mag_s;
                    div_d   = b_mag_s;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
`ifdef DIVISOR_SIGNED_EN
                    sa_d    = A[N_W-1];
                    sq_d    = A[N_W-1] ^ B[D_W-1];
`endif
                    if (B != '0) begin
                        dz_d = 1'b0;
                    end else begin
                        dz_d = dz_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (div_q == '0) begin
                    quo_d   = '1;
                    res_d   = res_dz_s;
                    dz_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    work_d = work_nxt_s;
                    rem_d  = rem_nxt_s;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        quo_d   = quo_fix_s;
                        res_d   = res_fix_s;
                        dz_d    = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset also aborts any division in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
            sa_q    <= 1'b0;
            sq_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
`ifdef DIVISOR_SIGNED_EN
            sa_q    <= sa_d;
            sq_q    <= sq_d;
`endif
        end
    end

    assign q        = quo_q;
    assign r        = res_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dz       = dz_q;
    assign contador = cnt_q;

endmodule

// File: tb/tb_divisor.sv
// Self-checking bench for divisor: fixed vectors, hand-written corner sequences
// and random operands against an arithmetic reference model.
module tb_divisor;

    localparam int N_W = 16;
    localparam int D_W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N_W-1:0] A;
    logic [D_W-1:0] B;
    logic [N_W-1:0] q;
    logic [D_W-1:0] r;
    logic           busy;
    logic           done;
    logic           dz;
    logic [4:0]     contador;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } vec_t;

    vec_t vecs [6];

    divisor #(.N_W(N_W), .D_W(D_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .dz       (dz),
        .contador (contador)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] eq, output logic [7:0] er,
                                  output logic edz);
        logic [15:0] t;
        int sa, sb, qi, ri;
        if (b == 8'd0) begin
            eq  = 16'hFFFF;
            er  = a[7:0];
            edz = 1'b1;
        end else begin
            edz = 1'b0;
`ifdef DIVISOR_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            qi = sa / sb;
            ri = sa % sb;
            eq = qi[15:0];
            er = ri[7:0];
            t  = 16'd0;
`else
            sa = 0; sb = 0; qi = 0; ri = 0;
            eq = a / {8'd0, b};
            t  = a % {8'd0, b};
            er = t[7:0];
`endif
        end
    endfunction

    // Start one division at the next negedge and check its result and timing.
    task automatic run_div(input string nm, input logic [15:0] a, input logic [7:0] b,
                           input logic [15:0] eq, input logic [7:0] er, input logic edz);
        int k;
        int lat;
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({nm, " busy_after_start"}, busy, 1);
        lat = edz ? 1 : N_W;
        k = 0;
        while (k < 40 && !done) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({nm, " latency"}, k, lat);
        chk({nm, " q"}, q, eq);
        chk({nm, " r"}, r, er);
        chk({nm, " dz"}, dz, edz);
        chk({nm, " busy_at_done"}, busy, 0);
        if (!edz) chk({nm, " contador"}, contador, N_W);
        @(posedge clk);
        #1;
        chk({nm, " done_pulse_width"}, done, 0);
    endtask

    initial begin
        logic [15:0] ra, eq;
        logic [7:0]  rb, er;
        logic        edz;
        int          pulses;
        int          pulse_at;
        logic [15:0] cap_q;
        logic [7:0]  cap_r;

`ifdef DIVISOR_SIGNED_EN
        vecs[0] = '{16'hFF9C, 8'd7,   16'hFFF2, 8'hFE, 1'b0};
        vecs[1] = '{16'd100,  8'hF9,  16'hFFF2, 8'h02, 1'b0};
        vecs[2] = '{16'h8000, 8'hFF,  16'h8000, 8'h00, 1'b0};
        vecs[3] = '{16'd1234, 8'd0,   16'hFFFF, 8'hD2, 1'b1};
        vecs[4] = '{16'd9,    8'd3,   16'd3,    8'd0,  1'b0};
        vecs[5] = '{16'd100,  8'd7,   16'd14,   8'd2,  1'b0};
`else
        vecs[0] = '{16'd100,   8'd7,   16'd14,   8'd2,  1'b0};
        vecs[1] = '{16'd65535, 8'd255, 16'd257,  8'd0,  1'b0};
        vecs[2] = '{16'd0,     8'd3,   16'd0,    8'd0,  1'b0};
        vecs[3] = '{16'd1234,  8'd0,   16'hFFFF, 8'hD2, 1'b1};
        vecs[4] = '{16'd9,     8'd3,   16'd3,    8'd0,  1'b0};
        vecs[5] = '{16'd5,     8'd200, 16'd0,    8'd5,  1'b0};
`endif

        rst   = 1'b0;
        start = 1'b0;
        A     = 16'd0;
        B     = 8'd0;
        #1;
        chk("reset q", q, 0);
        chk("reset r", r, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset dz", dz, 0);
        chk("reset contador", contador, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
        end

        // start held high through CALC and DONE with operands changing every cycle
        @(negedge clk);
        start = 1'b1;
        A     = 16'd100;
        B     = 8'd7;
        pulses   = 0;
        pulse_at = -1;
        cap_q    = 16'd0;
        cap_r    = 8'd0;
        @(posedge clk);
        for (int k = 1; k <= N_W + 4; k++) begin
            @(negedge clk);
            start = (k <= N_W + 1);
            A     = 16'($urandom);
            B     = 8'($urandom);
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                pulse_at = k;
                cap_q    = q;
                cap_r    = r;
            end
        end
        start = 1'b0;
        chk("held_start pulses", pulses, 1);
        chk("held_start pulse_edge", pulse_at, N_W);
        chk("held_start q", cap_q, 14);
        chk("held_start r", cap_r, 2);
        chk("held_start idle_busy", busy, 0);

        // asynchronous reset in the middle of an iteration sequence
        @(negedge clk);
        start = 1'b1;
        A     = 16'd100;
        B     = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort contador_before", contador, 8);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort q", q, 0);
        chk("abort r", r, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort dz", dz, 0);
        chk("abort contador", contador, 0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < N_W + 4; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("abort no_done", pulses, 0);
        run_div("after_abort", 16'd9, 8'd3, 16'd3, 8'd0, 1'b0);

        // random operands against the reference model
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            model(ra, rb, eq, er, edz);
            run_div($sformatf("rand%0d a=%0h b=%0h", i, ra, rb), ra, rb, eq, er, edz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
